dqs_rcv_check: RTL

DQS_RCV_CHECK -- requirements
Module: dqs_rcv_check

---
 rtl/dqs_rcv_check_pkg.sv | 21 ++
 rtl/dqs_rcv_check.sv | 135 +++++++++++++
 2 files changed

// File: rtl/dqs_rcv_check_pkg.sv
// Shared definitions for the DQS receive checker: FSM states, result codes
// and the DQS word patterns recognised on the parallel sample bus.
package dqs_rcv_check_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_PRE  = 2'd1,
    WAIT_EDGE = 2'd2,
    BURST     = 2'd3
  } state_t;

  localparam logic [1:0] ERR_OK       = 2'd0;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd1;
  localparam logic [1:0] ERR_BAD_EDGE = 2'd2;
  localparam logic [1:0] ERR_LENGTH   = 2'd3;

  localparam logic [3:0] PRE_WORD    = 4'b0000;
  localparam logic [3:0] TOGGLE_WORD = 4'b1010;
  localparam logic [3:0] EDGE3_WORD  = 4'b1000;

endpackage

// File: rtl/dqs_rcv_check.sv
// Measures read-return latency and burst length on the deserialised DQS
// samples: waits for preamble, locates the first edge, counts toggling words.
module dqs_rcv_check
  import dqs_rcv_check_pkg::*;
#(
  parameter int LAT_WIDTH = 8,
  parameter int CNT_WIDTH = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [LAT_WIDTH-1:0] max_wait,
  input  logic [CNT_WIDTH-1:0] burst_words,
  input  logic [3:0]           dqs_samples,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           err_code,
  output logic [LAT_WIDTH-1:0] latency,
  output logic [1:0]           phase,
  output logic [CNT_WIDTH-1:0] word_cnt
);

  function automatic logic [LAT_WIDTH-1:0] sat_inc_lat(input logic [LAT_WIDTH-1:0] v);
    return (v == {LAT_WIDTH{1'b1}}) ? v : v + 1'b1;
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_inc_cnt(input logic [CNT_WIDTH-1:0] v);
    return (v == {CNT_WIDTH{1'b1}}) ? v : v + 1'b1;
  endfunction

  state_t               state, state_nx;
  logic [LAT_WIDTH-1:0] lat_cnt;
  logic                 accept;
  logic                 cnt_run;
  logic                 edge_hit;
  logic [1:0]           edge_phase;
  logic                 word_inc;
  logic                 finish;
  logic [1:0]           fin_code;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    accept     = 1'b0;
    cnt_run    = 1'b0;
    edge_hit   = 1'b0;
    edge_phase = 2'd0;
    word_inc   = 1'b0;
    finish     = 1'b0;
    fin_code   = ERR_OK;
    unique case (state)
      IDLE: begin
        if (start) begin
          accept   = 1'b1;
          state_nx = WAIT_PRE;
        end
      end
      WAIT_PRE: begin
        cnt_run = 1'b1;
        // Non-zero words before preamble are the bus floating, not an error.
        if (lat_cnt == max_wait) begin
          finish   = 1'b1;
          fin_code = ERR_TIMEOUT;
        end else if (dqs_samples == PRE_WORD) begin
          state_nx = WAIT_EDGE;
        end
      end
      WAIT_EDGE: begin
        cnt_run = 1'b1;
        // An edge arriving on the timeout cycle still counts as a hit.
        if (dqs_samples == TOGGLE_WORD) begin
          edge_hit   = 1'b1;
          edge_phase = 2'd1;
          state_nx   = BURST;
        end else if (dqs_samples == EDGE3_WORD) begin
          edge_hit   = 1'b1;
          edge_phase = 2'd3;
          state_nx   = BURST;
        end else if (lat_cnt == max_wait) begin
          finish   = 1'b1;
          fin_code = ERR_TIMEOUT;
        end else if (dqs_samples != PRE_WORD) begin
          finish   = 1'b1;
          fin_code = ERR_BAD_EDGE;
        end
      end
      BURST: begin
        if (dqs_samples == TOGGLE_WORD) begin
          word_inc = 1'b1;
        end else begin
          finish   = 1'b1;
          fin_code = (word_cnt == burst_words) ? ERR_OK : ERR_LENGTH;
        end
      end
      default: state_nx = IDLE;
    endcase
    if (finish) state_nx = IDLE;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      lat_cnt  <= '0;
      done     <= 1'b0;
      err_code <= ERR_OK;
      latency  <= '0;
      phase    <= 2'd0;
      word_cnt <= '0;
    end else begin
      done <= finish;
      if (accept) begin
        lat_cnt  <= '0;
        err_code <= ERR_OK;
        latency  <= '0;
        phase    <= 2'd0;
        word_cnt <= '0;
      end else begin
        if (cnt_run) lat_cnt <= sat_inc_lat(lat_cnt);
        if (edge_hit) begin
          latency  <= lat_cnt;
          phase    <= edge_phase;
          word_cnt <= CNT_WIDTH'(1);
        end
        if (word_inc) word_cnt <= sat_inc_cnt(word_cnt);
        if (finish)   err_code <= fin_code;
      end
    end
  end

endmodule
